// File: rtl/pixel_write_scheduler.sv
// pixel_write_scheduler
//   Owns the single pixel-write port of vga_adapter. Two requesters share it:
//   a full-screen clear sequencer (runs out of reset or on clear_start, highest
//   priority) and a brush stamper that expands one accepted draw point into a
//   clipped BRUSH x BRUSH square. All vga_* outputs are registered, so a pixel
//   selected in cycle N is presented in cycle N+1.
//
//   Optional feature macro: STAMP_DEDUP_EN
//     defined   - a point equal to the last stamped (x,y,color) is accepted but
//                 not re-stamped; any CLEAR or reset forgets the stored point.
//     undefined - every accepted point is stamped.
//
// Ports
//   CLOCK_50        in   system clock
//   reset           in   asynchronous active-high reset
//   clear_start     in   one-cycle full-screen clear request
//   draw_valid      in   draw point offered
//   draw_ready      out  point accepted this cycle (IDLE and no clear_start)
//   draw_x/y/color  in   brush centre and colour
//   clearing_active out  clear sequence running
//   busy            out  any state other than IDLE
//   vga_x/y/color   out  registered pixel to vga_adapter
//   vga_write       out  registered write strobe
module pixel_write_scheduler #(
   parameter int                SCREEN_WIDTH  = 320,
   parameter int                SCREEN_HEIGHT = 240,
   parameter int                BRUSH         = 3,
   parameter logic [8:0]        CLEAR_COLOR   = 9'b111111111
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       clear_start,
   input  logic       draw_valid,
   output logic       draw_ready,
   input  logic [8:0] draw_x,
   input  logic [7:0] draw_y,
   input  logic [8:0] draw_color,
   output logic       clearing_active,
   output logic       busy,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [8:0] vga_color,
   output logic       vga_write
);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STAMP} state_t;

   localparam logic [8:0]        XMAX = 9'(SCREEN_WIDTH - 1);
   localparam logic [7:0]        YMAX = 8'(SCREEN_HEIGHT - 1);
   localparam logic [2:0]        BMAX = 3'(BRUSH - 1);
   localparam logic signed [10:0] HALF = 11'(BRUSH / 2);
   localparam logic signed [10:0] W11  = 11'(SCREEN_WIDTH);
   localparam logic signed [10:0] H11  = 11'(SCREEN_HEIGHT);

   state_t     state_q, state_d;
   logic [8:0] cx_q, cx_d;
   logic [7:0] cy_q, cy_d;
   logic [2:0] si_q, si_d, sj_q, sj_d;
   logic [8:0] x_q, x_d, col_q, col_d;
   logic [7:0] y_q, y_d;
   logic       dv_q, dv_d;
   logic       wr_q, wr_d;
   logic [8:0] ox_q, ox_d, oc_q, oc_d;
   logic [7:0] oy_q, oy_d;

   logic signed [10:0] px, py;
   logic               inb, dup;

   // Brush pixel in 11-bit signed space so off-screen offsets go negative
   // instead of wrapping into valid coordinates.
   assign px  = $signed({2'b00, x_q}) - HALF + $signed({8'b0, si_q});
   assign py  = $signed({3'b000, y_q}) - HALF + $signed({8'b0, sj_q});
   assign inb = !px[10] && !py[10] && (px < W11) && (py < H11);

`ifdef STAMP_DEDUP_EN
   assign dup = dv_q && (draw_x == x_q) && (draw_y == y_q) && (draw_color == col_q);
`else
   assign dup = 1'b0;
`endif

   assign draw_ready      = (state_q == S_IDLE) && !clear_start;
   assign clearing_active = (state_q == S_CLEAR);
   assign busy            = (state_q != S_IDLE);
   assign vga_x           = ox_q;
   assign vga_y           = oy_q;
   assign vga_color       = oc_q;
   assign vga_write       = wr_q;

   always_comb begin
      state_d = state_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      si_d    = si_q;
      sj_d    = sj_q;
      x_d     = x_q;
      y_d     = y_q;
      col_d   = col_q;
      dv_d    = dv_q;
      wr_d    = 1'b0;
      ox_d    = ox_q;
      oy_d    = oy_q;
      oc_d    = oc_q;
      case (state_q)
         S_IDLE: begin
            if (clear_start) begin
               state_d = S_CLEAR;
               cx_d    = '0;
               cy_d    = '0;
            end else if (draw_valid) begin
               x_d   = draw_x;
               y_d   = draw_y;
               col_d = draw_color;
               // A duplicate completes the handshake but stays in IDLE.
               if (!dup) begin
                  state_d = S_STAMP;
                  si_d    = '0;
                  sj_d    = '0;
                  dv_d    = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            dv_d = 1'b0;
            wr_d = 1'b1;
            ox_d = cx_q;
            oy_d = cy_q;
            oc_d = CLEAR_COLOR;
            if (clear_start) begin
               cx_d = '0;
               cy_d = '0;
            end else if (cx_q == XMAX) begin
               cx_d = '0;
               if (cy_q == YMAX) state_d = S_IDLE;
               else              cy_d    = cy_q + 8'd1;
            end else begin
               cx_d = cx_q + 9'd1;
            end
         end
         S_STAMP: begin
            if (clear_start) begin
               // Abort: the current stamp pixel is dropped so the next strobe
               // is the first clear pixel.
               state_d = S_CLEAR;
               cx_d    = '0;
               cy_d    = '0;
            end else begin
               wr_d = inb;
               ox_d = px[8:0];
               oy_d = py[7:0];
               oc_d = col_q;
               if (si_q == BMAX) begin
                  si_d = '0;
                  if (sj_q == BMAX) state_d = S_IDLE;
                  else              sj_d    = sj_q + 3'd1;
               end else begin
                  si_d = si_q + 3'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_CLEAR;
         cx_q    <= '0;
         cy_q    <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         col_q   <= '0;
         dv_q    <= 1'b0;
         wr_q    <= 1'b0;
         ox_q    <= '0;
         oy_q    <= '0;
         oc_q    <= CLEAR_COLOR;
      end else begin
         state_q <= state_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col_q   <= col_d;
         dv_q    <= dv_d;
         wr_q    <= wr_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         oc_q    <= oc_d;
      end
   end

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Directed bench for pixel_write_scheduler at W=8, H=4, BRUSH=3.
// A monitor logs every vga_write strobe; tests compare the log against
// hand-computed expectations.
module tb_pixel_write_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear_start = 1'b0;
   logic       draw_valid = 1'b0;
   logic       draw_ready;
   logic [8:0] draw_x = '0;
   logic [7:0] draw_y = '0;
   logic [8:0] draw_color = '0;
   logic       clearing_active, busy, vga_write;
   logic [8:0] vga_x, vga_color;
   logic [7:0] vga_y;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [8:0] c;
   } wr_t;

   wr_t wq[$];

   typedef struct {
      logic [8:0] x;
      logic [7:0] y;
      logic [8:0] c;
      int         n_wr;
      wr_t        first;
      wr_t        last;
   } vec_t;

   vec_t vecs[6];

   pixel_write_scheduler #(
      .SCREEN_WIDTH (8),
      .SCREEN_HEIGHT(4),
      .BRUSH        (3),
      .CLEAR_COLOR  (9'h1FF)
   ) dut (
      .CLOCK_50       (clk),
      .reset          (rst),
      .clear_start    (clear_start),
      .draw_valid     (draw_valid),
      .draw_ready     (draw_ready),
      .draw_x         (draw_x),
      .draw_y         (draw_y),
      .draw_color     (draw_color),
      .clearing_active(clearing_active),
      .busy           (busy),
      .vga_x          (vga_x),
      .vga_y          (vga_y),
      .vga_color      (vga_color),
      .vga_write      (vga_write)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst && vga_write) wq.push_back({vga_x, vga_y, vga_color});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Checks 32 raster-order clear strobes starting at wq[base].
   task automatic check_clear(input string name, input int base);
      int bad = 0;
      for (int i = 0; i < 32; i++) begin
         wr_t e = {9'(i % 8), 8'(i / 8), 9'h1FF};
         if (base + i >= wq.size() || wq[base + i] !== e) bad++;
      end
      check(name, bad, 0);
   endtask

   task automatic wait_clear_done(input string name);
      int n = 0;
      while (clearing_active && n < 200) begin @(posedge clk); #1; n++; end
      check({name, "_timeout"}, (n >= 200), 0);
      @(negedge clk); @(negedge clk);
   endtask

   // Offers one point, completes the handshake, returns busy cycles.
   task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [8:0] c,
                       output int cyc);
      int n = 0;
      while (!draw_ready && n < 200) begin @(posedge clk); #1; n++; end
      @(negedge clk);
      draw_x = x; draw_y = y; draw_color = c; draw_valid = 1'b1;
      check("send_ready", draw_ready, 1'b1);
      @(posedge clk); #1;
      draw_valid = 1'b0;
      wq.delete();
      cyc = 0;
      while (busy && cyc < 200) begin @(posedge clk); #1; cyc++; end
      @(negedge clk); @(negedge clk);
   endtask

   initial begin
      int cyc, n, bad;

      vecs[0] = '{9'd4, 8'd2, 9'h0A5, 9, {9'd3, 8'd1, 9'h0A5}, {9'd5, 8'd3, 9'h0A5}};
      vecs[1] = '{9'd0, 8'd0, 9'h011, 4, {9'd0, 8'd0, 9'h011}, {9'd1, 8'd1, 9'h011}};
      vecs[2] = '{9'd7, 8'd3, 9'h1C0, 4, {9'd6, 8'd2, 9'h1C0}, {9'd7, 8'd3, 9'h1C0}};
      vecs[3] = '{9'd0, 8'd3, 9'h007, 4, {9'd0, 8'd2, 9'h007}, {9'd1, 8'd3, 9'h007}};
      vecs[4] = '{9'd7, 8'd0, 9'h038, 4, {9'd6, 8'd0, 9'h038}, {9'd7, 8'd1, 9'h038}};
      vecs[5] = '{9'd3, 8'd1, 9'h155, 9, {9'd2, 8'd0, 9'h155}, {9'd4, 8'd2, 9'h155}};

      // 1. reset state and power-on clear
      #12;
      check("rst_write", vga_write, 1'b0);
      check("rst_xy", {vga_x, vga_y}, 17'h0);
      check("rst_color", vga_color, 9'h1FF);
      check("rst_ready", draw_ready, 1'b0);
      check("rst_clearing", clearing_active, 1'b1);
      check("rst_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (clearing_active && n < 200) begin @(posedge clk); #1; n++; end
      check("clear_cycles", n, 32);
      @(negedge clk); @(negedge clk);
      check("clear_count", wq.size(), 32);
      check_clear("clear_order", 0);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", draw_ready, 1'b1);

      // 2/3. table of stamps including clipped corners and edges
      foreach (vecs[k]) begin
         send(vecs[k].x, vecs[k].y, vecs[k].c, cyc);
         check($sformatf("v%0d_cycles", k), cyc, 9);
         check($sformatf("v%0d_nwr", k), wq.size(), vecs[k].n_wr);
         if (wq.size() > 0) begin
            check($sformatf("v%0d_first", k), wq[0], vecs[k].first);
            check($sformatf("v%0d_last", k), wq[wq.size() - 1], vecs[k].last);
         end
      end

      // full pixel list for the centred stamp
      send(9'd4, 8'd2, 9'h0A5, cyc);
      bad = 0;
      for (int j = 0; j < 3; j++)
         for (int i = 0; i < 3; i++)
            if (wq.size() != 9 || wq[j * 3 + i] !== {9'(3 + i), 8'(1 + j), 9'h0A5}) bad++;
      check("stamp_list", bad, 0);

      // 4. clear_start on the 4th stamp cycle aborts the stamp
      @(negedge clk);
      draw_x = 9'd4; draw_y = 8'd1; draw_color = 9'h0A5; draw_valid = 1'b1;
      @(posedge clk); #1;
      draw_valid = 1'b0;
      wq.delete();
      @(posedge clk); @(posedge clk); @(posedge clk);
      @(negedge clk);
      clear_start = 1'b1;
      @(posedge clk); #1;
      clear_start = 1'b0;
      check("abort_clearing", clearing_active, 1'b1);
      wait_clear_done("abort");
      check("abort_count", wq.size(), 35);
      if (wq.size() >= 3) check("abort_pre", wq[2], {9'd5, 8'd0, 9'h0A5});
      check_clear("abort_clear", 3);

      // 5. clear_start and draw_valid together: clear wins, point held
      @(negedge clk);
      draw_x = 9'd2; draw_y = 8'd1; draw_color = 9'h03C;
      draw_valid = 1'b1; clear_start = 1'b1;
      #1;
      check("coll_ready", draw_ready, 1'b0);
      @(posedge clk); #1;
      clear_start = 1'b0;
      check("coll_clearing", clearing_active, 1'b1);
      wq.delete();
      n = 0;
      while (!draw_ready && n < 200) begin @(posedge clk); #1; n++; end
      check("coll_wait", n, 32);
      @(posedge clk); #1;
      draw_valid = 1'b0;
      check("coll_clear_count", wq.size(), 32);
      check_clear("coll_clear", 0);
      wq.delete();
      check("coll_busy", busy, 1'b1);
      cyc = 0;
      while (busy && cyc < 200) begin @(posedge clk); #1; cyc++; end
      @(negedge clk); @(negedge clk);
      check("coll_cycles", cyc, 9);
      check("coll_nwr", wq.size(), 9);
      if (wq.size() > 0) check("coll_first", wq[0], {9'd1, 8'd0, 9'h03C});

      // 6. repeated point
      send(9'd4, 8'd2, 9'h0A5, cyc);
      check("dup1_cycles", cyc, 9);
      send(9'd4, 8'd2, 9'h0A5, cyc);
`ifdef STAMP_DEDUP_EN
      check("dup2_cycles", cyc, 0);
      check("dup2_nwr", wq.size(), 0);
`else
      check("dup2_cycles", cyc, 9);
      check("dup2_nwr", wq.size(), 9);
`endif
      @(negedge clk);
      clear_start = 1'b1;
      @(posedge clk); #1;
      clear_start = 1'b0;
      wait_clear_done("dup_clr");
      send(9'd4, 8'd2, 9'h0A5, cyc);
      check("dup3_cycles", cyc, 9);
      check("dup3_nwr", wq.size(), 9);

      // asynchronous reset mid-stamp
      @(negedge clk);
      draw_x = 9'd3; draw_y = 8'd2; draw_color = 9'h0F0; draw_valid = 1'b1;
      @(posedge clk); #1;
      draw_valid = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("arst_write", vga_write, 1'b0);
      check("arst_color", vga_color, 9'h1FF);
      check("arst_clearing", clearing_active, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      wq.delete();
      wait_clear_done("arst");
      check("arst_count", wq.size(), 32);
      check_clear("arst_clear", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
